// File: rtl/fft_digit_reverse_reorder.sv
// ---------------------------------------------------------------------------
// fft_digit_reverse_reorder
//
// Output reorder stage for a radix-4 SDF FFT. Accepts a 4-lane stream in
// base-4 digit-reversed order and emits the same frame on 4 lanes in natural
// bin order. Two buffer halves (ping/pong), each made of 4 banks of depth
// N/4, let one frame be written while the previous one is read, so
// back-to-back frames stream without stalls.
//
// Storage mapping for bin n:  bank = (top digit of n + n[1:0]) mod 4,
//                             address = n >> 2.
// This mapping is conflict-free for the 4 writes of an input beat and for
// the 4 reads of an output beat.
//
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   input_en                     : input beat valid (4 samples)
//   input_real_0..3/imag_0..3    : input lanes, digit-reversed order
//   output_en                    : output beat valid
//   output_last                  : final (N/4-th) beat of an output frame
//   output_real_0..3/imag_0..3   : output lanes, natural order
//                                  (values hold while output_en is low)
// ---------------------------------------------------------------------------
module fft_digit_reverse_reorder #(
    parameter int WIDTH          = 16,
    parameter int Num_of_samples = 4096
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             input_en,
    input  logic [WIDTH-1:0] input_real_0,
    input  logic [WIDTH-1:0] input_real_1,
    input  logic [WIDTH-1:0] input_real_2,
    input  logic [WIDTH-1:0] input_real_3,
    input  logic [WIDTH-1:0] input_imag_0,
    input  logic [WIDTH-1:0] input_imag_1,
    input  logic [WIDTH-1:0] input_imag_2,
    input  logic [WIDTH-1:0] input_imag_3,
    output logic             output_en,
    output logic             output_last,
    output logic [WIDTH-1:0] output_real_0,
    output logic [WIDTH-1:0] output_real_1,
    output logic [WIDTH-1:0] output_real_2,
    output logic [WIDTH-1:0] output_real_3,
    output logic [WIDTH-1:0] output_imag_0,
    output logic [WIDTH-1:0] output_imag_1,
    output logic [WIDTH-1:0] output_imag_2,
    output logic [WIDTH-1:0] output_imag_3
);

    localparam int N  = Num_of_samples;
    localparam int Q  = N / 4;            // beats per frame
    localparam int AW = $clog2(Q);        // beat counter / bank address width
    localparam int PW = AW + 2;           // stream position / bin width
    localparam int D  = PW / 2;           // base-4 digits per index
    localparam int DW = 2 * WIDTH;        // packed {real, imag}

    typedef enum logic {
        S_IDLE,
        S_READ
    } state_t;

    // Reverse the D base-4 digits of an index.
    function automatic logic [PW-1:0] digitrev4(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        r = '0;
        for (int k = 0; k < D; k++) begin
            r[2*k +: 2] = p[2*(D-1-k) +: 2];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Input lanes packed as {real, imag}
    // ------------------------------------------------------------------
    logic [DW-1:0] in_lane [4];
    assign in_lane[0] = {input_real_0, input_imag_0};
    assign in_lane[1] = {input_real_1, input_imag_1};
    assign in_lane[2] = {input_real_2, input_imag_2};
    assign in_lane[3] = {input_real_3, input_imag_3};

    // ------------------------------------------------------------------
    // Write side: beat counter, write half pointer, half-full flags
    // ------------------------------------------------------------------
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic          whalf_q, whalf_d;
    logic [1:0]    full_q, full_d;
    logic          wr_last;

    // Read side
    state_t        state_q, state_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic          rhalf_q, rhalf_d;
    logic          rd_en;
    logic          rd_last;

    assign wr_last = input_en && (wcnt_q == AW'(Q - 1));

    always_comb begin
        wcnt_d  = wcnt_q;
        whalf_d = whalf_q;
        if (input_en) begin
            wcnt_d = wr_last ? '0 : wcnt_q + 1'b1;
            if (wr_last) begin
                whalf_d = ~whalf_q;
            end
        end
    end

    // A half is freed in the same cycle its last address is read; the write
    // side may already be filling it from that cycle on.
    always_comb begin
        full_d = full_q;
        if (rd_en && rd_last) begin
            full_d[rhalf_q] = 1'b0;
        end
        if (wr_last) begin
            full_d[whalf_q] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read FSM. In IDLE the first address is issued in the same cycle the
    // full flag is seen, which gives the two-cycle input-to-output latency
    // and keeps consecutive frames contiguous.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        rhalf_d = rhalf_q;
        rd_en   = 1'b0;
        rd_last = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (full_q[rhalf_q]) begin
                    rd_en   = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                rd_en = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (rd_en) begin
            rd_last = (raddr_q == AW'(Q - 1));
            raddr_d = raddr_q + 1'b1;      // wraps to 0 after the last address
            if (rd_last) begin
                rhalf_d = ~rhalf_q;
                state_d = full_q[~rhalf_q] ? S_READ : S_IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wcnt_q  <= '0;
            whalf_q <= 1'b0;
            full_q  <= '0;
            state_q <= S_IDLE;
            raddr_q <= '0;
            rhalf_q <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            whalf_q <= whalf_d;
            full_q  <= full_d;
            state_q <= state_d;
            raddr_q <= raddr_d;
            rhalf_q <= rhalf_d;
        end
    end

    // ------------------------------------------------------------------
    // Banks. Each bank holds both halves (half select is the address MSB),
    // with one write port and one registered read port.
    // ------------------------------------------------------------------
    logic [4*DW-1:0] rd_bus;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bank
            logic [DW-1:0] mem [0:2*Q-1];
            logic [DW-1:0] rd_q;
            logic [1:0]    lane_sel;
            logic [PW-1:0] n_bin;
            logic [AW-1:0] waddr;

            // Lane l lands in bank (l + top digit of beat) mod 4, so bank gi
            // takes the lane that rotates onto it.
            assign lane_sel = 2'(gi) - wcnt_q[AW-1:AW-2];
            assign n_bin    = digitrev4({wcnt_q, lane_sel});
            assign waddr    = AW'(n_bin >> 2);

            always_ff @(posedge clock) begin
                if (input_en && !reset) begin
                    mem[{whalf_q, waddr}] <= in_lane[lane_sel];
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    rd_q <= '0;
                end else if (rd_en) begin
                    rd_q <= mem[{rhalf_q, raddr_q}];
                end
            end

            assign rd_bus[gi*DW +: DW] = rd_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output control and crossbar. Bin 4m+j sits in bank (top digit of m
    // + j) mod 4, so the rotation is latched alongside the read.
    // ------------------------------------------------------------------
    logic       output_en_q;
    logic       output_last_q;
    logic [1:0] rot_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            output_en_q   <= 1'b0;
            output_last_q <= 1'b0;
            rot_q         <= '0;
        end else begin
            output_en_q   <= rd_en;
            output_last_q <= rd_en && rd_last;
            if (rd_en) begin
                rot_q <= raddr_q[AW-1:AW-2];
            end
        end
    end

    logic [4*DW-1:0] out_bus;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_xbar
            logic [1:0] src;
            assign src = 2'(gi) + rot_q;
            assign out_bus[gi*DW +: DW] = rd_bus[int'(src)*DW +: DW];
        end
    endgenerate

    assign output_en     = output_en_q;
    assign output_last   = output_last_q;
    assign output_real_0 = out_bus[0*DW+WIDTH +: WIDTH];
    assign output_imag_0 = out_bus[0*DW       +: WIDTH];
    assign output_real_1 = out_bus[1*DW+WIDTH +: WIDTH];
    assign output_imag_1 = out_bus[1*DW       +: WIDTH];
    assign output_real_2 = out_bus[2*DW+WIDTH +: WIDTH];
    assign output_imag_2 = out_bus[2*DW       +: WIDTH];
    assign output_real_3 = out_bus[3*DW+WIDTH +: WIDTH];
    assign output_imag_3 = out_bus[3*DW       +: WIDTH];

endmodule
